// File: rtl/mem_rmw_ctrl.sv
// Data-memory access sequencer between the LSU and a single-port word RAM.
// Loads are fetched and extended; sub-word stores go through read-modify-write.
module mem_rmw_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // LSU request / response
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [ADDR_WIDTH-1:0] req_wdata_i,
  input  logic [1:0]            mem_type_i,
  input  logic                  load_unsigned_i,
  output logic                  rsp_valid_o,
  output logic [ADDR_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  // data RAM
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [ADDR_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [ADDR_WIDTH-1:0] mem_rdata_i,
  // external store-merge block
  output logic [ADDR_WIDTH-1:0] merge_read_data_o,
  output logic [ADDR_WIDTH-1:0] merge_addr_o,
  output logic [1:0]            merge_type_o,
  input  logic [ADDR_WIDTH-1:0] merge_data_i
);

  localparam logic [1:0] TYPE_BYTE = 2'b01;
  localparam logic [1:0] TYPE_HALF = 2'b10;
  localparam int         CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_RWAIT,
    ST_WRITE,
    ST_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, wdata_q, rdata_q;
  logic [1:0]            type_q;
  logic                  we_q, unsigned_q, err_q;
  logic [CNT_W-1:0]      cnt_q, cnt_inc;
  logic                  timeout_hit;
  logic                  req_is_word, q_is_word;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [ADDR_WIDTH-1:0] load_ext;

  assign req_is_word = (mem_type_i != TYPE_BYTE) && (mem_type_i != TYPE_HALF);
  assign q_is_word   = (type_q != TYPE_BYTE) && (type_q != TYPE_HALF);
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (cnt_inc == CNT_LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = (req_we_i && req_is_word) ? ST_WRITE : ST_READ;
      end
      ST_READ: begin
        mem_req_o = 1'b1;
        state_d   = ST_RWAIT;
      end
      ST_RWAIT: begin
        // Data arriving on the last allowed cycle still beats the timeout.
        if (mem_rvalid_i)     state_d = we_q ? ST_WRITE : ST_RESP;
        else if (timeout_hit) state_d = ST_RESP;
      end
      ST_WRITE: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: these are plain control/data registers, not a memory array, so all
  // of them are reset to give deterministic outputs straight out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      type_q     <= '0;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            addr_q     <= req_addr_i;
            wdata_q    <= req_wdata_i;
            type_q     <= mem_type_i;
            we_q       <= req_we_i;
            unsigned_q <= load_unsigned_i;
          end
        end
        ST_READ: cnt_q <= '0;
        ST_RWAIT: begin
          if (mem_rvalid_i) begin
            rdata_q <= mem_rdata_i;
          end else begin
            cnt_q <= cnt_inc;
            if (timeout_hit) err_q <= 1'b1;
          end
        end
        ST_RESP: err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (addr_q[1:0])
      2'd1:    load_byte = rdata_q[15:8];
      2'd2:    load_byte = rdata_q[23:16];
      2'd3:    load_byte = rdata_q[31:24];
      default: load_byte = rdata_q[7:0];
    endcase
    load_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (type_q)
      TYPE_BYTE: load_ext = {{24{load_byte[7] & ~unsigned_q}}, load_byte};
      TYPE_HALF: load_ext = {{16{load_half[15] & ~unsigned_q}}, load_half};
      default:   load_ext = rdata_q;
    endcase
  end

  assign rsp_err_o         = (state_q == ST_RESP) && err_q;
  assign rsp_rdata_o       = ((state_q == ST_RESP) && !we_q) ? load_ext : '0;
  assign mem_addr_o        = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata_o       = (state_q == ST_WRITE) ? (q_is_word ? wdata_q : merge_data_i) : '0;
  assign merge_read_data_o = rdata_q;
  assign merge_addr_o      = addr_q;
  assign merge_type_o      = type_q;

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Directed bench for mem_rmw_ctrl: word RAM model, reference store-merge
// block, a vector table and hand sequences for timeout/reset/back-to-back.
module tb_mem_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  mem_type = '0;
  logic        load_unsigned = 1'b0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] merge_read_data, merge_addr, merge_data;
  logic [1:0]  merge_type;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_rmw_ctrl #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .mem_type_i(mem_type),
    .load_unsigned_i(load_unsigned),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .merge_read_data_o(merge_read_data), .merge_addr_o(merge_addr),
    .merge_type_o(merge_type), .merge_data_i(merge_data)
  );

  // RAM model: read data one cycle after the strobe unless auto mode is off.
  logic [31:0] ram [0:255];
  logic        ram_auto = 1'b1;
  logic        auto_rv = 1'b0;
  logic [31:0] auto_rd = '0;
  logic        man_rv = 1'b0;
  logic [31:0] man_rd = '0;
  logic        poke = 1'b0;
  logic [7:0]  poke_idx = '0;
  logic [31:0] poke_data = '0;
  int          wr_cnt = 0, rd_cnt = 0;
  logic [31:0] last_waddr = '0, last_wmerge = '0;

  assign mem_rvalid = auto_rv | man_rv;
  assign mem_rdata  = man_rv ? man_rd : auto_rd;

  always @(posedge clk) begin
    auto_rv <= ram_auto && mem_req && !mem_we;
    auto_rd <= ram[mem_addr[9:2]];
    if (poke) ram[poke_idx] <= poke_data;
    if (mem_req && mem_we) begin
      ram[mem_addr[9:2]] <= mem_wdata;
      wr_cnt      <= wr_cnt + 1;
      last_waddr  <= mem_addr;
      last_wmerge <= merge_read_data;
    end
    if (mem_req && !mem_we) rd_cnt <= rd_cnt + 1;
  end

  // Reference store-merge block.
  logic [31:0] st_data = '0;
  always_comb begin
    merge_data = merge_read_data;
    case (merge_type)
      2'b01:   merge_data[8*merge_addr[1:0] +: 8] = st_data[7:0];
      2'b10:   merge_data[16*merge_addr[1] +: 16] = st_data[15:0];
      default: merge_data = st_data;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_ram(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    poke = 1'b1; poke_idx = addr[9:2]; poke_data = data;
    @(negedge clk);
    poke = 1'b0;
  endtask

  // Issue one request at cycle 0; optionally force rvalid during cycle rv_cycle.
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] typ, input logic uns,
                         input int rv_cycle, input logic [31:0] rv_data,
                         output int lat, output logic [31:0] rdata, output logic err);
    lat = -1; rdata = 'x; err = 1'bx;
    @(negedge clk);
    st_data = wdata;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    mem_type = typ; load_unsigned = uns;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      man_rv = 1'b0;
      if (rsp_valid) begin
        lat = k; rdata = rsp_rdata; err = rsp_err;
        break;
      end
      if (k == rv_cycle) begin
        man_rv = 1'b1; man_rd = rv_data;
      end
    end
    man_rv = 1'b0;
    if (lat < 0) $display("FAIL rsp_timeout: got no response within 40 cycles");
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  typ;
    logic        uns;
    logic [31:0] init;
    logic [31:0] exp_rdata;
    logic [31:0] exp_word;
    int          exp_lat;
    int          exp_reads;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int          lat, wr0, rd0;
    logic [31:0] rdata;
    logic        err;
    int          rsp_k [$];
    logic [31:0] rsp_d [$];

    vecs[0]  = '{1'b1, 32'h100, 32'hDEADBEEF, 2'b00, 1'b0, 32'h0000_0000, 32'h0, 32'hDEADBEEF, 2, 0};
    vecs[1]  = '{1'b1, 32'h103, 32'h0000_00AB, 2'b01, 1'b0, 32'h1122_3344, 32'h0, 32'hAB22_3344, 4, 1};
    vecs[2]  = '{1'b0, 32'h100, 32'h0,         2'b01, 1'b0, 32'h8001_3380, 32'hFFFF_FF80, 32'h8001_3380, 3, 1};
    vecs[3]  = '{1'b0, 32'h100, 32'h0,         2'b01, 1'b1, 32'h8001_3380, 32'h0000_0080, 32'h8001_3380, 3, 1};
    vecs[4]  = '{1'b0, 32'h102, 32'h0,         2'b10, 1'b0, 32'h8001_3380, 32'hFFFF_8001, 32'h8001_3380, 3, 1};
    vecs[5]  = '{1'b0, 32'h102, 32'h0,         2'b10, 1'b1, 32'h8001_3380, 32'h0000_8001, 32'h8001_3380, 3, 1};
    vecs[6]  = '{1'b0, 32'h101, 32'h0,         2'b01, 1'b0, 32'h8001_3380, 32'h0000_0033, 32'h8001_3380, 3, 1};
    vecs[7]  = '{1'b0, 32'h103, 32'h0,         2'b01, 1'b0, 32'h8001_3380, 32'hFFFF_FF80, 32'h8001_3380, 3, 1};
    vecs[8]  = '{1'b0, 32'h101, 32'h0,         2'b10, 1'b0, 32'h8001_3380, 32'h0000_3380, 32'h8001_3380, 3, 1};
    vecs[9]  = '{1'b0, 32'h103, 32'h0,         2'b11, 1'b0, 32'h8001_3380, 32'h8001_3380, 32'h8001_3380, 3, 1};
    vecs[10] = '{1'b1, 32'h102, 32'h0000_CAFE, 2'b10, 1'b0, 32'h1122_3344, 32'h0, 32'hCAFE_3344, 4, 1};
    vecs[11] = '{1'b1, 32'h101, 32'h1234_BEEF, 2'b10, 1'b0, 32'h1122_3344, 32'h0, 32'h1122_BEEF, 4, 1};
    vecs[12] = '{1'b1, 32'h101, 32'hFFFF_FF77, 2'b01, 1'b0, 32'h1122_3344, 32'h0, 32'h1122_7744, 4, 1};
    vecs[13] = '{1'b1, 32'h104, 32'h0BAD_F00D, 2'b11, 1'b0, 32'h5555_5555, 32'h0, 32'h0BAD_F00D, 2, 0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_merge_rd", merge_read_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);

    // Vector table
    for (int i = 0; i < 14; i++) begin
      set_ram(vecs[i].addr, vecs[i].init);
      wr0 = wr_cnt; rd0 = rd_cnt;
      run_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].typ, vecs[i].uns,
              0, 32'h0, lat, rdata, err);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), 32'(err), 32'd0);
      check($sformatf("v%0d_word", i), ram[vecs[i].addr[9:2]], vecs[i].exp_word);
      check($sformatf("v%0d_reads", i), 32'(rd_cnt - rd0), 32'(vecs[i].exp_reads));
      check($sformatf("v%0d_writes", i), 32'(wr_cnt - wr0), 32'(vecs[i].we ? 1 : 0));
      if (vecs[i].we) check($sformatf("v%0d_waddr", i), last_waddr, {vecs[i].addr[31:2], 2'b00});
      if (vecs[i].we && vecs[i].exp_reads == 1)
        check($sformatf("v%0d_merge_rd", i), last_wmerge, vecs[i].init);
    end

    // Reset while the word write strobe is up drops the write
    wr0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h108; req_wdata = 32'h1234_5678; mem_type = 2'b00;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("wr_strobe_up", 32'({mem_req, mem_we}), 32'd3);
    rst_n = 1'b0;
    #1;
    check("wr_strobe_dropped", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("wr_dropped_count", 32'(wr_cnt - wr0), 32'd0);

    // Request held across two transfers
    set_ram(32'h100, 32'h8001_3380);
    set_ram(32'h104, 32'h1234_5678);
    rd0 = rd_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; mem_type = 2'b01; load_unsigned = 1'b1;
    @(posedge clk); #1;
    req_addr = 32'h104; mem_type = 2'b00; load_unsigned = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (rsp_valid) begin rsp_k.push_back(k); rsp_d.push_back(rsp_rdata); end
      if (k <= 3 || k == 5) check($sformatf("b2b_ready_c%0d", k), 32'(req_ready), 32'd0);
      if (k == 4) check("b2b_ready_c4", 32'(req_ready), 32'd1);
      if (k == 5) req_valid = 1'b0;
    end
    check("b2b_rsp_count", 32'(rsp_k.size()), 32'd2);
    if (rsp_k.size() == 2) begin
      check("b2b_lat0", 32'(rsp_k[0]), 32'd3);
      check("b2b_data0", rsp_d[0], 32'h0000_0080);
      check("b2b_lat1", 32'(rsp_k[1]), 32'd7);
      check("b2b_data1", rsp_d[1], 32'h1234_5678);
    end
    check("b2b_reads", 32'(rd_cnt - rd0), 32'd2);

    // rvalid on the last allowed RWAIT cycle wins over the timeout
    ram_auto = 1'b0;
    run_req(1'b0, 32'h100, 32'h0, 2'b00, 1'b0, 17, 32'h0000_00FF, lat, rdata, err);
    check("late_rv_lat", 32'(lat), 32'd18);
    check("late_rv_err", 32'(err), 32'd0);
    check("late_rv_data", rdata, 32'h0000_00FF);

    // Sub-word store with no read data: timeout, no write
    wr0 = wr_cnt; rd0 = rd_cnt;
    run_req(1'b1, 32'h100, 32'h0000_0055, 2'b01, 1'b0, 0, 32'h0, lat, rdata, err);
    check("to_lat", 32'(lat), 32'd18);
    check("to_err", 32'(err), 32'd1);
    check("to_writes", 32'(wr_cnt - wr0), 32'd0);
    check("to_reads", 32'(rd_cnt - rd0), 32'd1);

    // Stray rvalid in IDLE is dropped
    @(negedge clk);
    man_rv = 1'b1; man_rd = 32'hFFFF_FFFF;
    @(negedge clk);
    man_rv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stray_busy_c%0d", k), 32'({rsp_valid, mem_req, req_ready}), 32'd1);
      @(negedge clk);
    end
    check("stray_rdata_kept", merge_read_data, 32'h0000_00FF);

    // Reset while waiting for read data
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; mem_type = 2'b00;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rwait_rst_outs", 32'({rsp_valid, rsp_err, mem_req, mem_we}), 32'd0);
    check("rwait_rst_addr", mem_addr, 32'h0);
    check("rwait_rst_merge", merge_read_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_c%0d", k), 32'({mem_req, req_ready}), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
